mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 76 +++++++
 rtl/mc_controller_alu_decoder.sv | 30 +++
 rtl/mc_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// Holds the FSM state enum, opcode constants and every datapath select encoding.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_REG   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  function automatic imm_src_t imm_src_for(input logic [6:0] opcode);
    imm_src_t imm;
    case (opcode)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU operation decode from the FSM's ALUOp plus instruction fields.
module alu_decoder
  import mc_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type with funct7[5] set is a subtract; addi with a negative imm is still add.
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore-FSM control unit for a multicycle RISC-V datapath (lw/sw/R/I/beq/jal).
// Write enables are gated while reset_n is low so no architectural state changes in reset.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [3:0] state_o
);

  state_t      state_q;
  state_t      state_d;
  alu_op_t     alu_op;
  result_src_t result_src;
  alu_src_a_t  alu_src_a;
  alu_src_b_t  alu_src_b;
  logic        adr_src;
  logic        ir_write_raw;
  logic        mem_write_raw;
  logic        reg_write_raw;
  logic        pc_update;
  logic        branch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    adr_src       = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURESULT;
        pc_update    = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm is computed here so beq has its target ready in ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // Link value OldPC+4 lands in ALUOut while PC takes the jump target.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  assign PCWrite   = reset_n & (pc_update | (branch & Zero));
  assign IRWrite   = reset_n & ir_write_raw;
  assign RegWrite  = reset_n & reg_write_raw;
  assign MemWrite  = reset_n & mem_write_raw;
  assign AdrSrc    = adr_src;
  assign ResultSrc = result_src;
  assign ALUSrcA   = alu_src_a;
  assign ALUSrcB   = alu_src_b;
  assign ImmSrc    = imm_src_for(op);
  assign state_o   = state_q;

endmodule
